// File: rtl/vga_pong_engine.sv
// Parametrised VGA timing generator with a Pong renderer and frame-synchronous game logic.
// Game state only changes on FrameTick, so a displayed frame never tears.
module vga_pong_engine #(
  parameter int unsigned H_VA        = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SP        = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VA        = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SP        = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned PIX_DIV     = 2,
  parameter int unsigned CW          = 4,
  parameter int unsigned PAD_W       = 15,
  parameter int unsigned PAD_H       = 80,
  parameter int unsigned PAD_L_X     = 0,
  parameter int unsigned PAD_R_X     = 625,
  parameter int unsigned WALL_H      = 6,
  parameter int unsigned BALL_SIZE   = 16,
  parameter int unsigned BALL_STEP   = 2,
  parameter int unsigned MISS_FRAMES = 60
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Enable,
  input  logic          Serve,
  input  logic [10:0]   PadL_Y,
  input  logic [10:0]   PadR_Y,
  output logic          HSync,
  output logic          VSync,
  output logic [CW-1:0] R,
  output logic [CW-1:0] G,
  output logic [CW-1:0] B,
  output logic [10:0]   HPos,
  output logic [10:0]   VPos,
  output logic          FrameTick,
  output logic          MissL,
  output logic          MissR
);

  localparam int unsigned H_TOT = H_VA + H_FP + H_SP + H_BP;
  localparam int unsigned V_TOT = V_VA + V_FP + V_SP + V_BP;
  localparam int unsigned DivW  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(PIX_DIV - 1);
  localparam logic [10:0] HLast = 11'(H_TOT - 1), VLast = 11'(V_TOT - 1);
  localparam logic [11:0] HVa = 12'(H_VA), VVa = 12'(V_VA);
  localparam logic [11:0] HSyncStart = 12'(H_VA + H_FP), HSyncLen = 12'(H_SP);
  localparam logic [11:0] VSyncStart = 12'(V_VA + V_FP), VSyncLen = 12'(V_SP);
  localparam logic [11:0] Bs = 12'(BALL_SIZE), Step = 12'(BALL_STEP);
  localparam logic [11:0] PadW = 12'(PAD_W), PadH = 12'(PAD_H);
  localparam logic [11:0] PadLX = 12'(PAD_L_X), PadRX = 12'(PAD_R_X);
  localparam logic [11:0] WallH = 12'(WALL_H), WallBot = 12'(V_VA - WALL_H);
  localparam logic [11:0] PadMin = 12'(WALL_H), PadMax = 12'(V_VA - WALL_H - PAD_H);
  localparam logic [11:0] BallXMax = 12'(H_VA - BALL_SIZE), BallYMax = 12'(V_VA - BALL_SIZE);
  localparam logic [11:0] BallX0 = 12'((H_VA - BALL_SIZE) / 2);
  localparam logic [11:0] BallY0 = 12'((V_VA - BALL_SIZE) / 2);
  localparam logic [11:0] PadY0 = 12'((V_VA - PAD_H) / 2);
  localparam logic [11:0] TopLim = 12'(WALL_H + BALL_STEP);
  localparam logic [11:0] BotLim = 12'(V_VA - WALL_H - BALL_STEP);
  localparam logic [11:0] LPadLim = 12'(PAD_L_X + PAD_W);
  localparam logic [11:0] RMissLim = 12'(H_VA - BALL_SIZE - BALL_STEP);
  localparam logic [11:0] MissLast = 12'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StMiss} state_e;

  logic [DivW-1:0] div_q;
  logic [10:0]     h_q, v_q;
  logic [11:0]     hx, vy;
  logic            pe, h_last, v_last;
  state_e          st_q;
  logic [11:0]     ball_x_q, ball_y_q, pad_l_q, pad_r_q, miss_cnt_q;
  logic            x_right_q, y_down_q, fg_q;

  assign pe        = (div_q == DivLast);
  assign h_last    = (h_q == HLast);
  assign v_last    = (v_q == VLast);
  assign FrameTick = pe & h_last & v_last;
  assign HPos      = h_q;
  assign VPos      = v_q;
  assign hx        = {1'b0, h_q};
  assign vy        = {1'b0, v_q};
  assign R         = {CW{fg_q}};
  assign G         = {CW{fg_q}};
  assign B         = {CW{fg_q}};

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= pe ? '0 : div_q + DivW'(1);
      if (pe) begin
        h_q <= h_last ? '0 : h_q + 11'd1;
        if (h_last) v_q <= v_last ? '0 : v_q + 11'd1;
      end
    end
  end

  // Unsigned wrap makes (pos - origin) < size a one-compare half-open range test.
  logic visible, ball_hit, pad_l_hit, pad_r_hit, wall_hit, fg_d;
  always_comb begin
    visible   = (hx < HVa) && (vy < VVa);
    ball_hit  = ((hx - ball_x_q) < Bs) && ((vy - ball_y_q) < Bs);
    pad_l_hit = ((hx - PadLX) < PadW) && ((vy - pad_l_q) < PadH);
    pad_r_hit = ((hx - PadRX) < PadW) && ((vy - pad_r_q) < PadH);
    wall_hit  = (vy < WallH) || (vy >= WallBot);
    // Every sprite draws in the same colour, so priority collapses to an OR.
    fg_d      = visible && (ball_hit || pad_l_hit || pad_r_hit || wall_hit);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      HSync <= ~SYNC_POL;
      VSync <= ~SYNC_POL;
      fg_q  <= 1'b0;
    end else if (pe) begin
      HSync <= ((hx - HSyncStart) < HSyncLen) ? SYNC_POL : ~SYNC_POL;
      VSync <= ((vy - VSyncStart) < VSyncLen) ? SYNC_POL : ~SYNC_POL;
      fg_q  <= fg_d;
    end
  end

  function automatic logic [11:0] clamp_pad(input logic [10:0] y);
    logic [11:0] y12;
    y12 = {1'b0, y};
    if (y12 < PadMin) return PadMin;
    if (y12 > PadMax) return PadMax;
    return y12;
  endfunction

  // Collisions use the pre-move ball and the paddles shown during the finishing frame.
  logic ol_l, ol_r, hit_top, hit_bot, bounce_l, bounce_r, miss_l, miss_r;
  logic x_right_n, y_down_n;
  logic [11:0] next_x, next_y;
  always_comb begin
    ol_l      = (ball_y_q < pad_l_q + PadH) && (ball_y_q + Bs > pad_l_q);
    ol_r      = (ball_y_q < pad_r_q + PadH) && (ball_y_q + Bs > pad_r_q);
    hit_top   = !y_down_q && (ball_y_q <= TopLim);
    hit_bot   = y_down_q && (ball_y_q + Bs >= BotLim);
    bounce_l  = !x_right_q && (ball_x_q <= LPadLim) && ol_l;
    miss_l    = !x_right_q && (ball_x_q <= Step) && !ol_l;
    bounce_r  = x_right_q && (ball_x_q + Bs >= PadRX) && ol_r;
    miss_r    = x_right_q && (ball_x_q >= RMissLim) && !ol_r;
    x_right_n = x_right_q ^ (bounce_l | bounce_r);
    y_down_n  = y_down_q ^ (hit_top | hit_bot);
    if (x_right_n) next_x = (ball_x_q + Step > BallXMax) ? BallXMax : ball_x_q + Step;
    else           next_x = (ball_x_q < Step) ? '0 : ball_x_q - Step;
    if (y_down_n)  next_y = (ball_y_q + Step > BallYMax) ? BallYMax : ball_y_q + Step;
    else           next_y = (ball_y_q < Step) ? '0 : ball_y_q - Step;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      st_q       <= StIdle;
      ball_x_q   <= BallX0;
      ball_y_q   <= BallY0;
      x_right_q  <= 1'b1;
      y_down_q   <= 1'b1;
      pad_l_q    <= PadY0;
      pad_r_q    <= PadY0;
      miss_cnt_q <= '0;
      MissL      <= 1'b0;
      MissR      <= 1'b0;
    end else begin
      MissL <= 1'b0;
      MissR <= 1'b0;
      if (FrameTick) begin
        pad_l_q <= clamp_pad(PadL_Y);
        pad_r_q <= clamp_pad(PadR_Y);
        case (st_q)
          StIdle: begin
            ball_x_q <= BallX0;
            ball_y_q <= BallY0;
            if (Serve) st_q <= StPlay;
          end
          StPlay: begin
            if (Enable) begin
              x_right_q <= x_right_n;
              y_down_q  <= y_down_n;
              if (miss_l || miss_r) begin
                MissL      <= miss_l;
                MissR      <= miss_r;
                miss_cnt_q <= '0;
                st_q       <= StMiss;
              end else begin
                ball_x_q <= next_x;
                ball_y_q <= next_y;
              end
            end
          end
          StMiss: begin
            if (miss_cnt_q == MissLast) begin
              st_q     <= StIdle;
              ball_x_q <= BallX0;
              ball_y_q <= BallY0;
            end else begin
              miss_cnt_q <= miss_cnt_q + 12'd1;
            end
          end
          default: st_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_pong_engine.sv
// Randomised bench for vga_pong_engine: a frame-level game model feeds a scoreboard queue,
// and a pixel monitor rebuilds every expected output from its own counters.
module tb_vga_pong_engine;

  localparam int H_VA = 32, H_FP = 2, H_SP = 4, H_BP = 2;
  localparam int V_VA = 24, V_FP = 1, V_SP = 2, V_BP = 1;
  localparam bit SYNC_POL = 1'b0;
  localparam int PIX_DIV = 2, CW = 4;
  localparam int PAD_W = 3, PAD_H = 6, PAD_L_X = 0, PAD_R_X = 29;
  localparam int WALL_H = 2, BALL_SIZE = 4, BALL_STEP = 2, MISS_FRAMES = 3;

  localparam int H_TOT = H_VA + H_FP + H_SP + H_BP;
  localparam int V_TOT = V_VA + V_FP + V_SP + V_BP;
  localparam int FRAME_CLKS = H_TOT * V_TOT * PIX_DIV;
  localparam int TICK_LIMIT = FRAME_CLKS + 50;
  localparam int NUM_FRAMES = 34;
  localparam int RESET_FRAME = 15;
  localparam int CX = (H_VA - BALL_SIZE) / 2, CY = (V_VA - BALL_SIZE) / 2;
  localparam int PAD0 = (V_VA - PAD_H) / 2;
  localparam int PAD_LO = WALL_H, PAD_HI = V_VA - WALL_H - PAD_H;
  localparam int M_IDLE = 0, M_PLAY = 1, M_MISS = 2;

  typedef struct {
    int bx, by, pl, pr;
    bit ml, mr;
  } rec_t;

  logic          Clock = 1'b0;
  logic          Resetn, Enable, Serve;
  logic [10:0]   PadL_Y, PadR_Y;
  logic          HSync, VSync, FrameTick, MissL, MissR;
  logic [CW-1:0] R, G, B;
  logic [10:0]   HPos, VPos;

  int   checks = 0;
  int   errors = 0;
  rec_t sb_q[$];

  // Game model state
  int m_st, m_cnt, m_bx, m_by, m_pl, m_pr;
  bit m_xr, m_yd;

  vga_pong_engine #(
    .H_VA(H_VA), .H_FP(H_FP), .H_SP(H_SP), .H_BP(H_BP),
    .V_VA(V_VA), .V_FP(V_FP), .V_SP(V_SP), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .PIX_DIV(PIX_DIV), .CW(CW),
    .PAD_W(PAD_W), .PAD_H(PAD_H), .PAD_L_X(PAD_L_X), .PAD_R_X(PAD_R_X),
    .WALL_H(WALL_H), .BALL_SIZE(BALL_SIZE), .BALL_STEP(BALL_STEP), .MISS_FRAMES(MISS_FRAMES)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .Serve(Serve),
    .PadL_Y(PadL_Y), .PadR_Y(PadR_Y), .HSync(HSync), .VSync(VSync),
    .R(R), .G(G), .B(B), .HPos(HPos), .VPos(VPos),
    .FrameTick(FrameTick), .MissL(MissL), .MissR(MissR)
  );

  always #5 Clock = ~Clock;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic rec_t reset_rec();
    rec_t r;
    r.bx = CX; r.by = CY; r.pl = PAD0; r.pr = PAD0; r.ml = 0; r.mr = 0;
    return r;
  endfunction

  function automatic bit render(input int h, input int v, input rec_t r);
    if (h >= H_VA || v >= V_VA) return 0;
    if (h >= r.bx && h < r.bx + BALL_SIZE && v >= r.by && v < r.by + BALL_SIZE) return 1;
    if (h >= PAD_L_X && h < PAD_L_X + PAD_W && v >= r.pl && v < r.pl + PAD_H) return 1;
    if (h >= PAD_R_X && h < PAD_R_X + PAD_W && v >= r.pr && v < r.pr + PAD_H) return 1;
    return (v < WALL_H) || (v >= V_VA - WALL_H);
  endfunction

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = 0; m_bx = CX; m_by = CY; m_pl = PAD0; m_pr = PAD0;
    m_xr = 1; m_yd = 1;
  endtask

  // One frame of game rules, applied at FrameTick with the inputs currently driven.
  task automatic model_step();
    rec_t r;
    bit ol_l, ol_r, ml, mr, nxr, nyd;
    ml = 0; mr = 0;
    if (m_st == M_IDLE) begin
      m_bx = CX; m_by = CY;
      if (Serve) m_st = M_PLAY;
    end else if (m_st == M_PLAY) begin
      if (Enable) begin
        ol_l = (m_by < m_pl + PAD_H) && (m_by + BALL_SIZE > m_pl);
        ol_r = (m_by < m_pr + PAD_H) && (m_by + BALL_SIZE > m_pr);
        nyd = m_yd;
        if (!m_yd && m_by <= WALL_H + BALL_STEP) nyd = 1;
        if (m_yd && m_by + BALL_SIZE >= V_VA - WALL_H - BALL_STEP) nyd = 0;
        nxr = m_xr;
        if (!m_xr && m_bx <= PAD_L_X + PAD_W && ol_l) nxr = 1;
        if (!m_xr && m_bx <= BALL_STEP && !ol_l) ml = 1;
        if (m_xr && m_bx + BALL_SIZE >= PAD_R_X && ol_r) nxr = 0;
        if (m_xr && m_bx >= H_VA - BALL_SIZE - BALL_STEP && !ol_r) mr = 1;
        m_xr = nxr; m_yd = nyd;
        if (ml || mr) begin
          m_st = M_MISS; m_cnt = 0;
        end else begin
          m_bx = m_xr ? clamp(m_bx + BALL_STEP, 0, H_VA - BALL_SIZE) : clamp(m_bx - BALL_STEP, 0, H_VA);
          m_by = m_yd ? clamp(m_by + BALL_STEP, 0, V_VA - BALL_SIZE) : clamp(m_by - BALL_STEP, 0, V_VA);
        end
      end
    end else begin
      if (m_cnt == MISS_FRAMES - 1) begin
        m_st = M_IDLE; m_bx = CX; m_by = CY;
      end else m_cnt++;
    end
    m_pl = clamp(int'(PadL_Y), PAD_LO, PAD_HI);
    m_pr = clamp(int'(PadR_Y), PAD_LO, PAD_HI);
    r.bx = m_bx; r.by = m_by; r.pl = m_pl; r.pr = m_pr; r.ml = ml; r.mr = mr;
    sb_q.push_back(r);
  endtask

  function automatic logic [10:0] pick_pad();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return 11'(clamp(m_by - 2, 0, 2047));
    if (r < 8) return 11'($urandom_range(0, 2047));
    return 11'd1000;
  endfunction

  task automatic randomize_inputs();
    Serve  = ($urandom_range(0, 9) < 7);
    Enable = ($urandom_range(0, 19) < 17);
    PadL_Y = pick_pad();
    PadR_Y = pick_pad();
  endtask

  task automatic wait_tick(output bit ok);
    int n;
    n = 0;
    ok = 0;
    while (n < TICK_LIMIT && !ok) begin
      @(negedge Clock);
      n++;
      if (FrameTick === 1'b1) ok = 1;
    end
  endtask

  task automatic mid_frame_reset();
    repeat ($urandom_range(200, 1200)) @(posedge Clock);
    #2 Resetn = 1'b0;
    #1;
    check("reset_hpos", int'(HPos), 0);
    check("reset_vpos", int'(VPos), 0);
    check("reset_rgb", int'({R, G, B}), 0);
    check("reset_sync", int'({HSync, VSync}), {2{~SYNC_POL}});
    check("reset_pulses", int'({FrameTick, MissL, MissR}), 0);
    model_reset();
    sb_q.delete();
    repeat (3) @(negedge Clock);
    #1 Resetn = 1'b1;
  endtask

  initial begin : driver
    bit ok;
    Resetn = 1'b0; Enable = 1'b0; Serve = 1'b0; PadL_Y = '0; PadR_Y = '0;
    model_reset();
    repeat (3) @(negedge Clock);
    #1 Resetn = 1'b1;
    randomize_inputs();
    for (int f = 0; f < NUM_FRAMES; f++) begin
      if (f == RESET_FRAME) mid_frame_reset();
      wait_tick(ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL frame_tick_timeout: no FrameTick within %0d clocks, required one", TICK_LIMIT);
        break;
      end
      model_step();
      @(posedge Clock);
      #1 randomize_inputs();
    end
    repeat (4) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Pixel monitor: own divider/counters, pops a frame record at every frame boundary.
  initial begin : monitor
    int md, mh, mv, frame;
    int bad_pix, bad_cnt, bad_sync, bad_ft, bad_miss;
    bit ehs, evs, efg, eml, emr, eft;
    rec_t cur;
    logic [CW-1:0] ergb;
    md = 0; mh = 0; mv = 0; frame = 0;
    bad_pix = 0; bad_cnt = 0; bad_sync = 0; bad_ft = 0; bad_miss = 0;
    ehs = ~SYNC_POL; evs = ~SYNC_POL; efg = 0;
    cur = reset_rec();
    forever begin
      @(negedge Clock);
      if (Resetn !== 1'b1) begin
        md = 0; mh = 0; mv = 0;
        ehs = ~SYNC_POL; evs = ~SYNC_POL; efg = 0;
        cur = reset_rec();
        continue;
      end
      eml = 0; emr = 0;
      if (md == PIX_DIV - 1) begin
        md = 0;
        ehs = (mh >= H_VA + H_FP && mh < H_VA + H_FP + H_SP) ? SYNC_POL : ~SYNC_POL;
        evs = (mv >= V_VA + V_FP && mv < V_VA + V_FP + V_SP) ? SYNC_POL : ~SYNC_POL;
        efg = render(mh, mv, cur);
        if (mh == H_TOT - 1 && mv == V_TOT - 1) begin
          check($sformatf("frame%0d_pixels", frame), bad_pix, 0);
          check($sformatf("frame%0d_counters", frame), bad_cnt, 0);
          check($sformatf("frame%0d_sync", frame), bad_sync, 0);
          check($sformatf("frame%0d_frametick", frame), bad_ft, 0);
          check($sformatf("frame%0d_spurious_miss", frame), bad_miss, 0);
          bad_pix = 0; bad_cnt = 0; bad_sync = 0; bad_ft = 0; bad_miss = 0;
          frame++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: frame end with 0 records, required 1");
          end else begin
            cur = sb_q.pop_front();
            eml = cur.ml;
            emr = cur.mr;
          end
        end
        if (mh == H_TOT - 1) begin
          mh = 0;
          mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end else mh++;
      end else md++;
      eft = (md == PIX_DIV - 1) && (mh == H_TOT - 1) && (mv == V_TOT - 1);
      ergb = efg ? '1 : '0;
      if (HPos !== 11'(mh) || VPos !== 11'(mv)) bad_cnt++;
      if (HSync !== ehs || VSync !== evs) bad_sync++;
      if (R !== ergb || G !== ergb || B !== ergb) bad_pix++;
      if (FrameTick !== eft) bad_ft++;
      if (eml || emr) check("miss_pulse", int'({MissL, MissR}), int'({eml, emr}));
      else if (MissL !== 1'b0 || MissR !== 1'b0) bad_miss++;
    end
  end

endmodule

// File: doc/vga_pong_engine.md
Name: vga_pong_engine

Overview:
- Parametrised successor to the fixed-640x480 monitor block: a generic VGA timing generator plus Pong renderer and game logic.
- Timing, sync polarity, pixel divider, colour depth and sprite geometry are all parameters.
- Paddle positions are external inputs; ball motion is frame-synchronous with paddle collision, miss detection and a serve state machine.
- Sits between the board controller/input logic and the VGA DAC pins.

Parameters:
H_VA 640 horizontal visible pixels; H_FP 16; H_SP 96; H_BP 48 (porches/sync, pixels)
V_VA 480 visible lines; V_FP 10; V_SP 2; V_BP 33 (lines)
SYNC_POL 0 sync active level (0 = active-low)
PIX_DIV 2 Clock cycles per pixel (>=1)
CW 4 bits per colour channel
PAD_W 15, PAD_H 80 paddle size; PAD_L_X 0, PAD_R_X 625 paddle left edges
WALL_H 6 top/bottom wall height
BALL_SIZE 16 square ball side; BALL_STEP 2 pixels moved per frame per axis
MISS_FRAMES 60 frames held in MISS before returning to IDLE

Ports:
Clock in 1 system clock
Resetn in 1 asynchronous active-low reset
Enable in 1 1 = ball motion allowed; timing always runs
Serve in 1 level/pulse, sampled at FrameTick
PadL_Y in 11 left paddle top edge request
PadR_Y in 11 right paddle top edge request
HSync out 1 horizontal sync
VSync out 1 vertical sync
R, G, B out CW each colour
HPos out 11 current horizontal counter
VPos out 11 current vertical counter
FrameTick out 1 one-Clock pulse on the last pixel of the frame
MissL out 1 one-Clock pulse, ball passed left paddle
MissR out 1 one-Clock pulse, ball passed right paddle

Behaviour:
- Reset (async, Resetn=0): divider, HPos, VPos = 0; HSync = VSync = ~SYNC_POL; RGB = 0; FrameTick, MissL, MissR = 0; ball at ((H_VA-BALL_SIZE)/2, (V_VA-BALL_SIZE)/2); x_dir right, y_dir down; paddles at (V_VA-PAD_H)/2; state IDLE. Reset mid-frame restarts the frame at (0,0).
- Pixel enable pe: asserted once every PIX_DIV Clocks; with PIX_DIV=1 it is tied high.
- Counters (advance on pe only): H_TOT = sum of the H parameters, V_TOT likewise. HPos counts 0..H_TOT-1 then wraps to 0. VPos increments on each HPos wrap and wraps after V_TOT-1.
- Sync: HSync = SYNC_POL when HPos is in [H_VA+H_FP, H_VA+H_FP+H_SP-1]; VSync is analogous.
- Output latency: HSync, VSync and RGB are registered on pe and reflect the counter value from before that pe (1 pixel latency).
- Colour:
  - Outside the visible area (HPos>=H_VA or VPos>=V_VA): RGB = 0.
  - Inside, priority is ball > paddles > walls > background. Foreground is all-ones on R/G/B; background is 0.
  - Sprite hit tests are half-open, e.g. ball_x <= HPos < ball_x+BALL_SIZE.
  - Walls cover VPos < WALL_H and VPos >= V_VA-WALL_H.
- FrameTick: pulses on the pe where HPos=H_TOT-1 and VPos=V_TOT-1. All game state updates happen only on FrameTick, so there is no tearing.
- Paddles: on FrameTick, PadX_Y is latched and clamped to [WALL_H, V_VA-WALL_H-PAD_H].
- State machine:
  - IDLE: ball is held at centre. On FrameTick with Serve=1, go to PLAY.
  - PLAY: if Enable=1, on each FrameTick move the ball by BALL_STEP in x_dir/y_dir. Positions saturate at 0 and at H_VA-BALL_SIZE / V_VA-BALL_SIZE; no wrap. If Enable=0, the ball is frozen.
  - MISS: frame counter runs 0..MISS_FRAMES-1. Then return to IDLE and recentre the ball, keeping x_dir (loser receives).
  - Serve is ignored outside IDLE.
- Collisions (PLAY, evaluated on FrameTick using pre-move position):
  - Top: y_dir up and ball_y <= WALL_H+BALL_STEP -> y_dir down.
  - Bottom: y_dir down and ball_y+BALL_SIZE >= V_VA-WALL_H-BALL_STEP -> y_dir up.
  - Left paddle: x_dir left, ball_x <= PAD_L_X+PAD_W, and vertical overlap with the paddle (ball_y < padL+PAD_H and ball_y+BALL_SIZE > padL) -> x_dir right.
  - Left miss: x_dir left, ball_x <= BALL_STEP, no overlap -> MissL pulse, go to MISS.
  - Right side is mirrored using PAD_R_X and H_VA-BALL_SIZE-BALL_STEP; a right miss pulses MissR.
  - A wall bounce and a paddle bounce in the same frame both flip their respective directions.
- Widths: internal arithmetic is 12 bits to avoid overflow in sums. Parameter totals must be <= 2047.

Test Plan:
- Defaults, PIX_DIV=2 -> HSync low for HPos 656..751, line period 1600 Clocks, frame 800x525; VSync low on lines 490..491; FrameTick period 840000 Clocks.
- Reset asserted at HPos=300 -> all outputs return to reset values within the same cycle; release -> HPos=0, VPos=0, RGB=0.
- Serve=1, Enable=1, paddles far from ball -> ball x advances 2 px per frame; reaching x<=2 with x_dir left -> exactly one MissL pulse; 60 frames later state is IDLE and ball is at (312,232).
- PadL_Y=200, ball heading left at y=230 -> x_dir flips at ball_x<=15, no MissL; PadL_Y=1000 -> latched as 394.
- Ball moving up near the top wall -> y_dir flips at ball_y<=8; the RGB pixel at (ball_x, ball_y) is all-ones (ball wins priority over wall).
- Enable=0 during PLAY for 10 frames -> ball position unchanged; HSync/VSync timing unaffected.
